// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with a valid/ready handshake.
// A main register drives the outputs. A skid register catches the one entry
// that can still be accepted in the cycle the downstream stalls. Because of
// the skid, in_ready can come straight from a flop. The stage also provides
// a synchronous flush, an exception/interrupt hold, and a saturating stall
// counter.
module pipe_stage_skid #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  // upstream side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_iack,
  input  logic [EXC_W-1:0]  in_exc,
  // downstream side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_iack,
  output logic [EXC_W-1:0]  out_exc,
  // status
  output logic              exc_hold,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy states. Main is valid in ONE and TWO. Skid is valid only in TWO.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              iack;
    logic [EXC_W-1:0]  exc;
  } entry_t;

  logic [1:0]       state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             exc_hold_q, exc_hold_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  entry_t in_ent;
  logic   main_vld;
  logic   acc;
  logic   rel;
  logic   faulting;

  assign in_ent   = '{pc: in_pc, data: in_data, iack: in_iack, exc: in_exc};
  assign main_vld = (state_q != ST_EMPTY);

  // in_ready is 0 while rst is asserted.
  // It is 1 as soon as rst is released, because rdy_q resets to 1.
  assign in_ready = rdy_q & ~rst;

  // in_ready gates accept, so any in_valid seen while not ready is ignored.
  assign acc      = in_valid & in_ready;
  assign rel      = main_vld & out_ready;

  // Interrupt acknowledge is treated like a fault: younger entries must wait.
  assign faulting = (in_exc != '0) | in_iack;

  // Occupancy, payload movement and hold flag. Flush overrides everything.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    exc_hold_d = exc_hold_q | (acc & faulting);
    if (flush) begin
      state_d    = ST_EMPTY;
      main_d     = '0;
      skid_d     = '0;
      exc_hold_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_d  = in_ent;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && rel) begin
            main_d = in_ent;
          end else if (acc) begin
            skid_d  = in_ent;
            state_d = ST_TWO;
          end else if (rel) begin
            // Payload is kept on drain; only out_valid falls.
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so the only event is the head leaving.
          if (rel) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Ready is computed from next-state values so it is a plain flop.
  // There is no combinational path from out_ready to in_ready.
  always_comb begin
    rdy_d = (state_d != ST_TWO) & ~exc_hold_d;
  end

  // Count stalled cycles: head present but not taken. Saturates at the top.
  // Flush does not clear the count.
  always_comb begin
    stall_d = stall_q;
    if (main_vld && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      exc_hold_q <= 1'b0;
      rdy_q      <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      exc_hold_q <= exc_hold_d;
      rdy_q      <= rdy_d;
      stall_q    <= stall_d;
    end
  end

  assign out_valid = main_vld;
  assign out_pc    = main_q.pc;
  assign out_data  = main_q.data;
  assign out_iack  = main_q.iack;
  assign out_exc   = main_q.exc;
  assign exc_hold  = exc_hold_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid.
// A reference queue model runs on the falling edge and checks every cycle.
// Scenario tasks add targeted inline checks.
module tb_pipe_stage_skid;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_iack = 1'b0;
  logic [EXC_W-1:0]  in_exc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic              out_iack;
  logic [EXC_W-1:0]  out_exc;
  logic              exc_hold;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              iack;
    logic [EXC_W-1:0]  exc;
  } ent_t;

  ent_t             m_q[$];
  logic             m_hold  = 1'b0;
  logic             m_ready = 1'b1;
  logic [CNT_W-1:0] m_cnt   = '0;

  pipe_stage_skid #(.PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_iack(in_iack), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_iack(out_iack), .out_exc(out_exc),
    .exc_hold(exc_hold), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard.
  // The bench pushes an expected entry whenever it drives an entry that
  // should be accepted. It pops that entry when the head is released.
  always @(negedge clk) begin
    ent_t e;
    logic acc, rel;
    if (rst) begin
      m_q.delete();
      m_hold  = 1'b0;
      m_ready = 1'b1;
      m_cnt   = '0;
    end else begin
      checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL sb_in_ready got %b exp %b t=%0t", in_ready, m_ready, $time); end
      checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL sb_out_valid got %b exp %b t=%0t", out_valid, (m_q.size() != 0), $time); end
      checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL sb_stall_cnt got %0d exp %0d t=%0t", stall_cnt, m_cnt, $time); end
      checks++; if (exc_hold !== m_hold) begin errors++; $display("FAIL sb_exc_hold got %b exp %b t=%0t", exc_hold, m_hold, $time); end
      if (m_q.size() != 0) begin
        checks++;
        if ({out_pc, out_data, out_iack, out_exc} !== {m_q[0].pc, m_q[0].data, m_q[0].iack, m_q[0].exc}) begin
          errors++;
          $display("FAIL sb_head got pc=%h data=%h iack=%b exc=%h exp pc=%h data=%h iack=%b exc=%h t=%0t",
                   out_pc, out_data, out_iack, out_exc, m_q[0].pc, m_q[0].data, m_q[0].iack, m_q[0].exc, $time);
        end
      end
      // Predict the effect of the coming rising edge.
      acc = in_valid && m_ready && !flush;
      rel = (m_q.size() != 0) && out_ready;
      if ((m_q.size() != 0) && !out_ready && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
      if (flush) begin
        m_q.delete();
        m_hold  = 1'b0;
        m_ready = 1'b1;
      end else begin
        if (rel) void'(m_q.pop_front());
        if (acc) begin
          e.pc = in_pc; e.data = in_data; e.iack = in_iack; e.exc = in_exc;
          m_q.push_back(e);
          if ((in_exc != '0) || in_iack) m_hold = 1'b1;
        end
        m_ready = (m_q.size() < 2) && !m_hold;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic iack, input logic [EXC_W-1:0] exc);
    in_valid = v;
    in_pc    = pc;
    in_data  = pc ^ 32'hA5A5_0000;
    in_iack  = iack;
    in_exc   = exc;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    step(2);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if ({out_pc, out_data, out_iack, out_exc} !== '0) begin errors++; $display("FAIL rst_payload got pc=%h data=%h exp 0", out_pc, out_data); end
    checks++; if (exc_hold !== 1'b0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_hold_cnt got %b/%0d exp 0/0", exc_hold, stall_cnt); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_high got %b exp 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 4'h0);
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_out got v=%b pc=%h exp v=1 pc=%h", out_valid, out_pc, 32'(4 * i)); end
      checks++; if (in_ready !== 1'b1 || stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_rdy got rdy=%b cnt=%0d exp 1/0", in_ready, stall_cnt); end
    end
    drive(1'b0, '0, 1'b0, 4'h0);
    step();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'hC) begin errors++; $display("FAIL stream_drain got v=%b pc=%h exp v=0 pc=0000000c", out_valid, out_pc); end
  endtask

  task automatic test_back_pressure();
    drive(1'b1, 32'h10, 1'b0, 4'h0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h14, 1'b0, 4'h0);
    step();
    checks++; if (out_pc !== 32'h10 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_two got pc=%h rdy=%b exp pc=00000010 rdy=0", out_pc, in_ready); end
    drive(1'b1, 32'h18, 1'b0, 4'h0);
    step(3);
    checks++; if (out_pc !== 32'h10 || in_ready !== 1'b0 || stall_cnt !== 4'd4) begin errors++; $display("FAIL bp_hold got pc=%h rdy=%b cnt=%0d exp 10/0/4", out_pc, in_ready, stall_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h14 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_rel1 got pc=%h rdy=%b exp 14/1", out_pc, in_ready); end
    step();
    checks++; if (out_pc !== 32'h18 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_rel2 got pc=%h v=%b exp 18/1", out_pc, out_valid); end
    drive(1'b0, '0, 1'b0, 4'h0);
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 4'd4) begin errors++; $display("FAIL bp_done got v=%b cnt=%0d exp 0/4", out_valid, stall_cnt); end
  endtask

  task automatic test_exception_hold();
    drive(1'b1, 32'h20, 1'b0, 4'h3);
    step();
    checks++; if (exc_hold !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL exc_set got hold=%b rdy=%b exp 1/0", exc_hold, in_ready); end
    checks++; if (out_pc !== 32'h20 || out_exc !== 4'h3) begin errors++; $display("FAIL exc_head got pc=%h exc=%h exp 20/3", out_pc, out_exc); end
    drive(1'b1, 32'h24, 1'b0, 4'h0);
    step();
    checks++; if (out_valid !== 1'b0 || out_exc !== 4'h3 || exc_hold !== 1'b1) begin errors++; $display("FAIL exc_drain got v=%b exc=%h hold=%b exp 0/3/1", out_valid, out_exc, exc_hold); end
    step(3);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL exc_block got v=%b rdy=%b exp 0/0", out_valid, in_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 4'h0);
    checks++; if (exc_hold !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL exc_flush got hold=%b rdy=%b exp 0/1", exc_hold, in_ready); end
    checks++; if (out_pc !== 32'h0 || out_exc !== 4'h0) begin errors++; $display("FAIL exc_flush_zero got pc=%h exc=%h exp 0/0", out_pc, out_exc); end
  endtask

  task automatic test_flush_two();
    out_ready = 1'b0;
    drive(1'b1, 32'h30, 1'b0, 4'h0);
    step();
    drive(1'b1, 32'h34, 1'b1, 4'h0);
    step();
    checks++; if (in_ready !== 1'b0 || exc_hold !== 1'b1 || out_pc !== 32'h30 || stall_cnt !== 4'd5) begin errors++; $display("FAIL ft_two got rdy=%b hold=%b pc=%h cnt=%0d exp 0/1/30/5", in_ready, exc_hold, out_pc, stall_cnt); end
    flush = 1'b1;
    drive(1'b1, 32'h40, 1'b0, 4'h0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 4'h0);
    checks++; if (out_valid !== 1'b0 || {out_pc, out_data, out_iack, out_exc} !== '0) begin errors++; $display("FAIL ft_zero got v=%b pc=%h data=%h iack=%b exc=%h exp all 0", out_valid, out_pc, out_data, out_iack, out_exc); end
    checks++; if (in_ready !== 1'b1 || exc_hold !== 1'b0 || stall_cnt !== 4'd6) begin errors++; $display("FAIL ft_status got rdy=%b hold=%b cnt=%0d exp 1/0/6", in_ready, exc_hold, stall_cnt); end
    out_ready = 1'b1;
    step(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ft_no_0x40 got v=%b pc=%h exp v=0", out_valid, out_pc); end
  endtask

  task automatic test_saturation_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 1'b0, 4'h5);
    step();
    drive(1'b0, '0, 1'b0, 4'h0);
    step(20);
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || exc_hold !== 1'b1 || out_pc !== 32'h50) begin errors++; $display("FAIL sat_state got v=%b hold=%b pc=%h exp 1/1/50", out_valid, exc_hold, out_pc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (stall_cnt !== 4'd0 || out_valid !== 1'b0 || exc_hold !== 1'b0) begin errors++; $display("FAIL async_rst got cnt=%0d v=%b hold=%b exp 0/0/0", stall_cnt, out_valid, exc_hold); end
    checks++; if (out_pc !== 32'h0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_rst_pc got pc=%h rdy=%b exp 0/0", out_pc, in_ready); end
    step();
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL post_rst got rdy=%b v=%b cnt=%0d exp 1/0/0", in_ready, out_valid, stall_cnt); end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 29) == 0) ? 4'h9 : 4'h0);
      step();
    end
    flush = 1'b1;
    drive(1'b0, '0, 1'b0, 4'h0);
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    step(3);
    checks++; if (out_valid !== 1'b0 || exc_hold !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rand_end got v=%b hold=%b rdy=%b exp 0/0/1", out_valid, exc_hold, in_ready); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_exception_hold();
    test_flush_two();
    test_saturation_reset();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline stage register, the general successor to the fixed IF/ID latch. It carries PC, instruction/data word, interrupt-acknowledge and an exception code between any two pipeline stages. It uses a valid/ready handshake with a 2-entry skid buffer, so throughput is full and the upstream ready is registered. It also adds synchronous flush, exception-hold (younger instructions are blocked after a faulting or interrupt-acknowledged entry until flush) and a saturating stall-cycle counter.

## Interface
- PC_W, 32, PC field width
- DATA_W, 32, data/instruction field width
- EXC_W, 4, exception code width; 0 = no exception
- CNT_W, 16, stall counter width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept; registered
- in_pc  input  PC_W  upstream PC
- in_data  input  DATA_W  upstream data word
- in_iack  input  1  upstream interrupt acknowledge
- in_exc  input  EXC_W  upstream exception code
- out_valid  output  1  entry present downstream; 0 = bubble
- out_ready  input  1  downstream accepts (replaces legacy staller, stall = ~out_ready)
- out_pc / out_data / out_iack / out_exc  output  PC_W / DATA_W / 1 / EXC_W  head entry fields
- exc_hold  output  1  stage blocked awaiting flush
- stall_cnt  output  CNT_W  cycles with out_valid & ~out_ready

## Operation
- Handshakes:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
  - in_valid is ignored when in_ready = 0. No combinational path from out_ready to in_ready.
- Storage:
  - Main register drives the outputs.
  - The skid register catches an accepted entry when the main register is valid and is not released in the same cycle.
- States: EMPTY (main invalid), ONE (main valid, skid empty), TWO (both valid).
- State transitions:
  - EMPTY: accept → ONE, with the entry loaded into main.
  - ONE, accept & release → ONE, with main loaded from input.
  - ONE, accept & ~release → TWO, with the entry loaded into skid.
  - ONE, release & ~accept → EMPTY.
  - TWO: accept is impossible (in_ready = 0).
  - TWO, release → ONE, with skid moved into main.
- in_ready (registered) = ~skid_valid_next & ~exc_hold_next.
- Exception hold:
  - Accepting an entry with in_exc ≠ 0 or in_iack = 1 sets exc_hold on the next edge.
  - While exc_hold = 1, in_ready = 0. Held entries still drain normally.
  - exc_hold clears only on flush or rst.
- Flush:
  - Highest priority over accept and release.
  - Next edge: main and skid invalid, all payload outputs = 0, exc_hold = 0, in_ready = 1, state EMPTY.
  - An input presented in the flush cycle is discarded, even if in_valid & in_ready.
  - Release in the flush cycle still counts downstream (the downstream stage sees it).
- Payload outputs hold their last value when out_valid falls through normal drain. They are zeroed only by flush/rst.
- stall_cnt:
  - +1 on each cycle with out_valid & ~out_ready, saturating at 2^CNT_W−1.
  - Unaffected by flush; cleared only by rst.
- Ordering: strict FIFO; skid always older than any later input.

## Timing
- Reset values (asynchronous, immediate on rst high):
  - out_valid = 0, out_pc = out_data = out_exc = 0, out_iack = 0.
  - exc_hold = 0, stall_cnt = 0, in_ready = 1 after rst deasserts. in_ready is held 0 while rst is high.
- Latency: an entry accepted at edge N is presented with out_valid = 1 after edge N, available for release at edge N+1.
- Throughput: one entry per cycle sustained with out_ready = 1.
- Back-pressure:
  - out_ready drop costs at most one extra accepted entry (skid).
  - in_ready falls the cycle after TWO is entered.
  - in_ready rises the cycle after TWO → ONE.
- Exception path: faulting entry accepted at edge N → exc_hold = 1 and in_ready = 0 after edge N.
- Flush at edge M → exc_hold = 0 and in_ready = 1 after edge M.
- Reset mid-operation (asynchronous) discards all entries; no partial state survives.

## Test plan
- Streaming:
  - Stimulus: rst pulse, then in_valid = 1, out_ready = 1, PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Response: out_pc 0x0, 0x4, 0x8, 0xC, one per cycle starting one cycle later; in_ready constantly 1; stall_cnt = 0.
- Back-pressure:
  - Stimulus: stream 0x10, 0x14, 0x18 with out_ready = 0 from the cycle 0x10 appears.
  - Response: 0x10 held on outputs, 0x14 captured in skid, in_ready = 0 the next cycle, 0x18 not accepted until released.
  - Then out_ready = 1: outputs 0x10, 0x14, 0x18 in order, no loss or duplication; stall_cnt equals the held cycles.
- Exception hold:
  - Stimulus: accept PC 0x20 with in_exc = 4'h3, then offer 0x24.
  - Response: exc_hold = 1, in_ready = 0; 0x20 drains with out_exc = 3; 0x24 is never accepted.
  - Then flush: exc_hold = 0, in_ready = 1.
- Flush in TWO state:
  - Stimulus: flush = 1 and in_valid = 1 (PC 0x40) in the same cycle.
  - Response: next cycle out_valid = 0, all payload outputs 0; 0x40 never appears.
- Saturation and reset:
  - Stimulus: CNT_W = 4, stall for 20 cycles.
  - Response: stall_cnt sticks at 15.
  - Then assert rst mid-cycle: stall_cnt, out_valid and exc_hold drop to 0 immediately, without waiting for a clk edge.
